// File: rtl/tread_input_mapper.sv
// Joystick front-end for tank cabinets: per-bit sync and debounce, player merge,
// tread steering (tank-8way / dual-stick / disabled) and coin pulse shaping into the JB byte.
`timescale 1ns/1ps
module tread_input_mapper #(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned COIN_PULSE_CYCLES = 5000,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                      clk_i,
  input  logic                      btnCpuReset,
  input  logic [16*NUM_PLAYERS-1:0] joy_i,
  input  logic [1:0]                mode_i,
  output logic [7:0]                jb_o,
  output logic                      coin_busy_o
);

  localparam int unsigned NB = 8 * NUM_PLAYERS;

  logic [NB-1:0]    w_joy;
  logic [NB-1:0]    w_unused_hi;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    w_deb;
  logic [7:0]       w_m;
  logic [3:0]       w_tank;
  logic [3:0]       w_dual;
  logic [3:0]       w_tread;
  logic [6:0]       r_jb_lo;
  logic             r_coin_busy;
  logic             r_coin_prev;
  logic [CNT_W-1:0] r_coin_cnt;

  // Only the low byte of each player word carries controls
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_split
    assign w_joy[8*p +: 8]       = joy_i[16*p +: 8];
    assign w_unused_hi[8*p +: 8] = joy_i[16*p + 8 +: 8];
  end

  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_joy;
      r_sync2 <= r_sync1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign w_deb = r_sync2;
  end else begin : g_deb
    logic [NB-1:0]    r_deb;
    logic [CNT_W-1:0] r_cnt [NB];

    // A bit is accepted only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
        r_deb <= '0;
        for (int i = 0; i < int'(NB); i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < int'(NB); i++) begin
          if (r_sync2[i] == r_deb[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end

    assign w_deb = r_deb;
  end

  always_comb begin
    w_m = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) w_m = w_m | w_deb[8*p +: 8];
  end

  // Tank map on merged {U,D,L,R}; result is {X_Fw, X_Bk, W_Fw, W_Bk}
  always_comb begin
    w_tank = 4'b0000;
    case (w_m[3:0])
      4'b1010: w_tank = 4'b1000;
      4'b1000: w_tank = 4'b1010;
      4'b1001: w_tank = 4'b0010;
      4'b0001: w_tank = 4'b0110;
      4'b0101: w_tank = 4'b0001;
      4'b0100: w_tank = 4'b0101;
      4'b0110: w_tank = 4'b0100;
      4'b0010: w_tank = 4'b1001;
      default: w_tank = 4'b0000;
    endcase
  end

  if (NUM_PLAYERS >= 2) begin : g_dual
    assign w_dual = { w_deb[11] & ~w_deb[10], w_deb[10] & ~w_deb[11],
                      w_deb[3]  & ~w_deb[2],  w_deb[2]  & ~w_deb[3] };
  end else begin : g_single
    assign w_dual = w_tank;
  end

  always_comb begin
    w_tread = 4'b0000;
    if (!mode_i[1]) w_tread = mode_i[0] ? w_dual : w_tank;
  end

  // Output register and coin pulse: one pulse per idle rising edge, no retrigger
  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      r_jb_lo     <= '0;
      r_coin_busy <= 1'b0;
      r_coin_prev <= 1'b0;
      r_coin_cnt  <= '0;
    end else begin
      r_jb_lo     <= {w_m[6:4], w_tread};
      r_coin_prev <= w_m[7];
      if (r_coin_busy) begin
        if (r_coin_cnt == '0) r_coin_busy <= 1'b0;
        else                  r_coin_cnt  <= r_coin_cnt - CNT_W'(1);
      end else if (w_m[7] && !r_coin_prev) begin
        r_coin_busy <= 1'b1;
        r_coin_cnt  <= CNT_W'(COIN_PULSE_CYCLES - 1);
      end
    end
  end

  assign jb_o        = {r_coin_busy, r_jb_lo};
  assign coin_busy_o = r_coin_busy;

endmodule
